// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: decode-stage issue controller with RAW/WAW register scoreboard and writer cap (optional WB_BYPASS_EN lets writeback clear hazards same cycle)
module decode_issue_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_CNT_W = 16,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  output logic                   id_ready,
  output logic                   issue_valid,
  output logic [31:0]            issue_instr,
  input  logic                   ex_ready,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [31:0]            busy_vec,
  output logic [OW-1:0]          outstanding,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;
  localparam logic [6:0] LOAD = 7'h03, OP_IMM = 7'h13, OP = 7'h33, BRANCH = 7'h63, STORE = 7'h23;
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] instr_q, busy_q, busy_eff, set_vec, clr_vec;
  logic [OW-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic uses_rs1, uses_rs2, writes_rd, hazard, fire, accept, inc, dec;
  assign opcode = instr_q[6:0];
  assign rd = instr_q[11:7];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign uses_rs1 = opcode inside {JALR, LOAD, OP_IMM, OP, BRANCH, STORE};
  assign uses_rs2 = opcode inside {OP, BRANCH, STORE};
  assign writes_rd = (opcode inside {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP}) && rd != 5'd0;
`ifdef WB_BYPASS_EN
  assign busy_eff = busy_q & ~(wb_valid ? 32'(1) << wb_rd : 32'd0);
`else
  assign busy_eff = busy_q;
`endif
  assign hazard = (uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2]) |
                  (writes_rd & busy_eff[rd]) | (writes_rd & (cnt_q == OW'(MAX_OUTSTANDING)));
  assign set_vec = (fire & writes_rd) ? 32'(1) << rd : 32'd0;
  assign clr_vec = (wb_valid & busy_q[wb_rd]) ? 32'(1) << wb_rd : 32'd0;
  assign inc = |set_vec;
  assign dec = |clr_vec;
  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // Next state: flush beats accept, accept keeps HOLD even on a fire
  always_comb begin
    state_d = flush ? EMPTY : accept ? HOLD : fire ? EMPTY : state_q;
  end
  // Handshake outputs; a flush cycle neither issues nor accepts
  always_comb begin
    issue_valid = (state_q == HOLD) & ~hazard & ~flush;
    fire = issue_valid & ex_ready;
    id_ready = ~flush & ((state_q == EMPTY) | fire);
    accept = if_valid & id_ready;
  end
  // Held instruction only changes on accept
  always_ff @(posedge clk) begin
    if (rst) instr_q <= 32'd0;
    else if (accept) instr_q <= if_instr;
  end
  // Scoreboard: clear then set so a same-register set wins and the count nets out
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
      cnt_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_vec) | set_vec;
      cnt_q <= (inc & ~dec) ? cnt_q + 1'b1 : (dec & ~inc) ? cnt_q - 1'b1 : cnt_q;
    end
  end
  // Saturating count of blocked HOLD cycles
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (state_q == HOLD && hazard && !(&stall_q)) stall_q <= stall_q + 1'b1;
  end
  assign issue_instr = instr_q;
  assign busy_vec = busy_q;
  assign outstanding = cnt_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: random and directed stimulus against a behavioural model with an issue scoreboard
module tb_decode_issue_ctrl;
  localparam int MO = 2, SW = 6, OW = $clog2(MO + 1);
  logic clk = 0, rst = 1, if_valid = 0, ex_ready = 0, wb_valid = 0, flush = 0;
  logic [31:0] if_instr = 0;
  logic [4:0] wb_rd = 0;
  logic id_ready, issue_valid;
  logic [31:0] issue_instr, busy_vec;
  logic [OW-1:0] outstanding;
  logic [SW-1:0] stall_cycles;
  decode_issue_ctrl #(.MAX_OUTSTANDING(MO), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy_vec(busy_vec),
    .outstanding(outstanding), .stall_cycles(stall_cycles));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit m_held = 0;
  logic [31:0] m_instr = 0;
  bit m_busy[32];
  int m_cnt = 0, m_stall = 0;
  logic [31:0] q[$];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic void uses(input logic [31:0] i, output bit u1, output bit u2, output bit w);
    case (i[6:0])
      7'h37, 7'h17, 7'h6f: {u1, u2, w} = 3'b001;
      7'h67, 7'h03, 7'h13: {u1, u2, w} = 3'b101;
      7'h33: {u1, u2, w} = 3'b111;
      7'h63, 7'h23: {u1, u2, w} = 3'b110;
      default: {u1, u2, w} = 3'b000;
    endcase
  endfunction
  function automatic bit m_hazard();
    bit u1, u2, w;
    bit b[32];
    int r1, r2, rd;
    b = m_busy;
`ifdef WB_BYPASS_EN
    if (wb_valid) b[wb_rd] = 0;
`endif
    uses(m_instr, u1, u2, w);
    r1 = m_instr[19:15];
    r2 = m_instr[24:20];
    rd = m_instr[11:7];
    return (u1 && r1 != 0 && b[r1]) || (u2 && r2 != 0 && b[r2]) ||
           (w && rd != 0 && (b[rd] || m_cnt == MO));
  endfunction
  function automatic bit m_iv();
    return m_held && !m_hazard() && !flush;
  endfunction
  function automatic bit m_rdy();
    return !flush && (!m_held || (m_iv() && ex_ready));
  endfunction
  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6f; 3: op = 7'h67; 4: op = 7'h03;
      5: op = 7'h13; 6: op = 7'h33; 7: op = 7'h63; 8: op = 7'h23; default: op = 7'h73;
    endcase
    r = $urandom;
    r[6:0] = op;
    r[11:7] = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction
  // Reference model state update
  always @(posedge clk) begin
    bit hz, fi, rdy, u1, u2, w;
    if (rst) begin
      m_held = 0; m_instr = 0; m_cnt = 0; m_stall = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      q.delete();
    end else begin
      hz = m_hazard();
      fi = m_held && !hz && !flush && ex_ready;
      rdy = !flush && (!m_held || fi);
      if (m_held && hz && m_stall < (1 << SW) - 1) m_stall++;
      if (wb_valid && wb_rd != 0 && m_busy[wb_rd]) begin
        m_busy[wb_rd] = 0;
        m_cnt--;
      end
      if (fi) begin
        uses(m_instr, u1, u2, w);
        if (w && m_instr[11:7] != 0) begin
          m_busy[m_instr[11:7]] = 1;
          m_cnt++;
        end
      end
      if (flush) begin
        m_held = 0;
        q.delete();
      end else if (if_valid && rdy) begin
        m_held = 1;
        m_instr = if_instr;
        q.push_back(if_instr);
      end else if (fi) m_held = 0;
    end
  end
  // Monitor: compare outputs mid-cycle, pop the scoreboard on every DUT issue
  always @(negedge clk) begin
    logic [31:0] bv;
    if (!rst) begin
      foreach (m_busy[i]) bv[i] = m_busy[i];
      chk("issue_valid", 32'(issue_valid), 32'(m_iv()));
      chk("id_ready", 32'(id_ready), 32'(m_rdy()));
      chk("busy_vec", busy_vec, bv);
      chk("outstanding", 32'(outstanding), 32'(m_cnt));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("issue_instr", issue_instr, m_instr);
      if (issue_valid && ex_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_fire: got issue of %0h expected no issue", issue_instr);
        end else chk("issue_fire", issue_instr, q.pop_front());
      end
    end
  end
  task automatic step(bit iv, logic [31:0] ins, bit er, bit wv, logic [4:0] wr, bit fl);
    if_valid = iv; if_instr = ins; ex_ready = er; wb_valid = wv; wb_rd = wr; flush = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_id_ready", 32'(id_ready), 1);
    chk("rst_busy", busy_vec, 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_instr", issue_instr, 0);
    // RAW stall on x5 long enough to saturate the stall counter
    step(1, 32'h00108293, 1, 0, 0, 0);
    step(1, mk(7'h33, 6, 5, 1), 1, 0, 0, 0);
    repeat (70) step(0, 0, 1, 0, 0, 0);
    chk("stall_sat", 32'(stall_cycles), (1 << SW) - 1);
    step(0, 0, 1, 1, 5, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 6, 0);
    // x0 destination never becomes busy
    step(1, mk(7'h13, 0, 0, 1), 1, 0, 0, 0);
    step(1, mk(7'h13, 7, 0, 1), 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 7, 0);
    // writer cap
    step(1, mk(7'h13, 1, 2, 3), 1, 0, 0, 0);
    step(1, mk(7'h13, 2, 2, 3), 1, 0, 0, 0);
    step(1, mk(7'h13, 3, 2, 3), 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    chk("cap_outstanding", 32'(outstanding), MO);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 2, 0);
    step(0, 0, 1, 1, 3, 0);
    // back-pressure then release with back-to-back accept
    step(1, mk(7'h63, 0, 4, 4), 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    chk("bp_instr", issue_instr, mk(7'h63, 0, 4, 4));
    step(1, mk(7'h23, 0, 1, 2), 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // flush while stalled keeps the scoreboard
    step(1, mk(7'h13, 5, 0, 1), 1, 0, 0, 0);
    step(1, mk(7'h33, 6, 5, 1), 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    step(1, mk(7'h13, 9, 0, 1), 1, 0, 0, 1);
    chk("flush_busy5", 32'(busy_vec[5]), 1);
    step(0, 0, 1, 1, 5, 0);
    for (int c = 0; c < 600; c++) begin
      rst = (c == 300 || c == 301);
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
